// File: rtl/led_pattern_gen_if.sv
// Configuration-write and LED-drive bundle for led_pattern_gen.
// master = configuring agent, slave = the pattern generator.
interface led_pattern_gen_if #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8
);
    logic                cfg_we;
    logic [3:0]          cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic [CHANNELS-1:0] led;
    logic                tick;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty, input led, tick);
    modport slave  (input cfg_we, cfg_ch, cfg_mode, cfg_duty, output led, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF / static PWM / blink / breathe per channel.
// Build option: define LED_PATTERN_BREATHE_EN to include the breathe engine; otherwise mode 3 acts as ON.
module led_pattern_ch #(
    parameter int PWM_BITS    = 8,
    parameter int BLINK_WRAPS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                frame_wrap,
    output logic                led
);
    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_t;
    localparam int BW = (BLINK_WRAPS > 1) ? $clog2(BLINK_WRAPS) : 1;

    mode_t               mode;
    logic [PWM_BITS-1:0] duty;
    logic [BW-1:0]       blink_cnt;
    logic                phase;
    logic                pwm_on;
    logic                led_next;

    assign pwm_on = (&duty) || (pwm_cnt < duty);

    // A write clears the pattern state, so it also suppresses any step on a coinciding frame wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= M_OFF;
            duty      <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            led       <= 1'b0;
        end else begin
            led <= led_next;
            if (wr) begin
                mode      <= mode_t'(wr_mode);
                duty      <= wr_duty;
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (frame_wrap && mode == M_BLINK) begin
                if (blink_cnt == BW'(BLINK_WRAPS - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    typedef enum logic {UP, DOWN} dir_t;
    dir_t                dir, dir_nxt;
    logic [PWM_BITS-1:0] bright, bright_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir    <= UP;
            bright <= '0;
        end else begin
            dir    <= dir_nxt;
            bright <= bright_nxt;
        end
    end

    // Turnaround frames hold bright, giving the 0..duty..0 triangle with doubled peaks.
    always_comb begin
        dir_nxt    = dir;
        bright_nxt = bright;
        if (wr) begin
            dir_nxt    = UP;
            bright_nxt = '0;
        end else if (frame_wrap && mode == M_BREATHE) begin
            unique case (dir)
                UP: begin
                    if (bright >= duty) dir_nxt = DOWN;
                    else                bright_nxt = bright + 1'b1;
                end
                DOWN: begin
                    if (bright == '0) dir_nxt = UP;
                    else              bright_nxt = bright - 1'b1;
                end
            endcase
        end
    end
`endif

    always_comb begin
        led_next = 1'b0;
        unique case (mode)
            M_OFF:     led_next = 1'b0;
            M_ON:      led_next = pwm_on;
            M_BLINK:   led_next = phase;
`ifdef LED_PATTERN_BREATHE_EN
            M_BREATHE: led_next = (pwm_cnt < bright);
`else
            M_BREATHE: led_next = pwm_on;
`endif
        endcase
    end
endmodule

module led_pattern_gen #(
    parameter int CHANNELS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int CLK_DIV     = 8,
    parameter int BLINK_WRAPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    led_pattern_gen_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick_q;
    logic                tick_en;
    logic                frame_wrap;
    logic [CHANNELS-1:0] led_q;

    assign tick_en    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_wrap = tick_en && (&pwm_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= tick_en;
            div_cnt <= tick_en ? '0 : div_cnt + 1'b1;
            if (tick_en) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        led_pattern_ch #(
            .PWM_BITS   (PWM_BITS),
            .BLINK_WRAPS(BLINK_WRAPS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr        (bus.cfg_we && (bus.cfg_ch == 4'(g))),
            .wr_mode   (bus.cfg_mode),
            .wr_duty   (bus.cfg_duty),
            .pwm_cnt   (pwm_cnt),
            .frame_wrap(frame_wrap),
            .led       (led_q[g])
        );
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;
endmodule
